bert_drp_arbiter: RTL and testbench
===================================

Name: bert_drp_arbiter

Overview:
- Parametrised DRP access engine between one management request port and NUM_LANES transceiver DRP ports, all in the DRP clock domain.
- Successor to the fixed two-lane, one-CDC-per-lane DRP path; scales to any lane count.
- Adds lane addressing, a per-transaction ready timeout with error reporting, and optional broadcast writes.
- Sits downstream of the management-side clock domain shifter and upstream of the GTX DRP pins.

Parameters:
NUM_LANES, 2, number of transceiver DRP ports (1..16)
ADDR_WIDTH, 9, DRP address width
DATA_WIDTH, 16, DRP data width
TIMEOUT, 255, cycles to wait for drp_rdy after issue before aborting (1..65535)
LANE_BITS, max(1,$clog2(NUM_LANES)), derived width of the lane select

Ports:
clk  in  1  DRP clock; all logic on rising edge
rst  in  1  asynchronous active-high reset
mgmt_en  in  1  single-cycle request strobe
mgmt_we  in  1  1 = write, 0 = read; sampled with mgmt_en
mgmt_lane  in  LANE_BITS  target lane; sampled with mgmt_en
mgmt_broadcast  in  1  write to all lanes; sampled with mgmt_en
mgmt_addr  in  ADDR_WIDTH  DRP address
mgmt_wdata  in  DATA_WIDTH  write data
mgmt_rdata  out  DATA_WIDTH  read data; valid when mgmt_done=1
mgmt_done  out  1  single-cycle completion pulse
mgmt_err  out  1  pulses with mgmt_done on timeout or illegal request
mgmt_busy  out  1  high from the cycle after an accepted mgmt_en until the cycle after mgmt_done
drp_en  out  NUM_LANES  per-lane DRP enable
drp_we  out  NUM_LANES  per-lane DRP write enable
drp_addr  out  ADDR_WIDTH  shared address, held for the whole transaction
drp_di  out  DATA_WIDTH  shared write data, held for the whole transaction
drp_do  in  NUM_LANES*DATA_WIDTH  per-lane read data; lane i at [i*DATA_WIDTH +: DATA_WIDTH]
drp_rdy  in  NUM_LANES  per-lane ready

Behaviour:
- Reset: all outputs 0; state IDLE; target mask, pending mask and timeout counter cleared. Reset mid-transaction aborts it with no done pulse. A late drp_rdy after reset is ignored.
- States are IDLE, ISSUE, WAIT and DONE.
- IDLE: mgmt_en=1 latches we, lane, broadcast, addr and wdata, then moves to ISSUE. mgmt_en while not IDLE is silently dropped, with no done and no err.
- Target mask:
  - unicast: one-hot of mgmt_lane;
  - broadcast: all NUM_LANES bits set.
- Illegal requests go directly to DONE with mgmt_err=1 and no drp_en driven:
  - unicast with mgmt_lane >= NUM_LANES;
  - broadcast with we=0;
  - broadcast while the feature is compiled out.
- ISSUE (1 cycle):
  - drp_en = target mask and drp_we = target mask & {NUM_LANES{we}};
  - pending = target mask; counter = 0; go to WAIT.
  - drp_rdy sampled in ISSUE is ignored.
- WAIT:
  - drp_en = drp_we = 0.
  - Each cycle, pending &= ~drp_rdy, and the counter increments.
  - drp_rdy on non-targeted lanes is ignored.
  - For a unicast read, capture drp_do of the target lane into the rdata register in the cycle its rdy is seen.
  - Pending becomes 0 (including when the final rdy arrives this cycle) -> DONE, err=0.
  - Counter reaches TIMEOUT-1 with pending != 0 -> DONE, err=1, rdata=0.
  - When both happen in the same cycle, completion wins (err=0).
- DONE (1 cycle): mgmt_done=1; mgmt_err as determined; mgmt_rdata driven (0 for writes/errors) and held until the next mgmt_done; go to IDLE.
- Latency, unicast: mgmt_en at cycle 0, drp_en at cycle 1, drp_rdy at cycle k (k>=2), mgmt_done at cycle k+1.
- Back-to-back: a new mgmt_en is accepted in the cycle after DONE (when IDLE).
- drp_addr and drp_di are registered at accept and stable from ISSUE through DONE.

Optional Feature:
- Macro: BERT_DRP_BROADCAST_EN.
- Defined: broadcast writes are supported as above. Completion requires every lane's rdy; each lane's rdy may arrive in any cycle and in any order.
- Undefined: the mgmt_broadcast input is still present but any request with it set is illegal (mgmt_err=1). Target mask logic reduces to unicast one-hot only.

Test Plan:
- Unicast read lane 1, addr 9'h05F; lane 1 drp_rdy 3 cycles after drp_en with drp_do=16'hBEEF -> drp_en=2'b10 for exactly one cycle, drp_we=0, mgmt_done 1 cycle after rdy, mgmt_rdata=16'hBEEF, mgmt_err=0.
- Unicast write lane 0, wdata 16'h1234; lane 1 spuriously asserts rdy while lane 0 is silent -> no completion on the spurious rdy. Lane 0 rdy at +5 -> mgmt_done, err=0, rdata=0, drp_we=2'b01 during ISSUE.
- TIMEOUT=8, no rdy -> mgmt_done and mgmt_err pulse exactly 8 cycles after ISSUE, rdata=0. A rdy injected 2 cycles later is ignored and the engine returns to IDLE.
- Broadcast write with NUM_LANES=4 and the macro defined; rdy in order lane 3, 0, 2, 1 on separate cycles -> drp_en=4'hF for one cycle, done 1 cycle after the lane 1 rdy. The same stimulus with the macro undefined gives immediate done+err and drp_en stays 0.
- Illegal lane: NUM_LANES=3, mgmt_lane=3 -> done+err 1 cycle after accept, no drp_en. A mgmt_en asserted during WAIT of a valid transaction is dropped: exactly one done pulse occurs.
- Assert rst during WAIT -> all outputs 0 immediately and no mgmt_done. The rdy arriving afterwards is ignored, and the next request completes normally.

Source files
------------

// File: rtl/bert_drp_arbiter.sv
// DRP access engine: one management request port fanned out to NUM_LANES transceiver DRP ports.
// Define BERT_DRP_BROADCAST_EN to enable broadcast writes; otherwise any broadcast request is illegal.
module bert_drp_arbiter #(
    parameter int NUM_LANES  = 2,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255,
    parameter int LANE_BITS  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            mgmt_en,
    input  logic                            mgmt_we,
    input  logic [LANE_BITS-1:0]            mgmt_lane,
    input  logic                            mgmt_broadcast,
    input  logic [ADDR_WIDTH-1:0]           mgmt_addr,
    input  logic [DATA_WIDTH-1:0]           mgmt_wdata,
    output logic [DATA_WIDTH-1:0]           mgmt_rdata,
    output logic                            mgmt_done,
    output logic                            mgmt_err,
    output logic                            mgmt_busy,
    output logic [NUM_LANES-1:0]            drp_en,
    output logic [NUM_LANES-1:0]            drp_we,
    output logic [ADDR_WIDTH-1:0]           drp_addr,
    output logic [DATA_WIDTH-1:0]           drp_di,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] drp_do,
    input  logic [NUM_LANES-1:0]            drp_rdy
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    state_t                 state, state_next;
    logic                   we_r;
    logic [LANE_BITS-1:0]   lane_r;
    logic [NUM_LANES-1:0]   mask_r;
    logic [NUM_LANES-1:0]   pend_r;
    logic [15:0]            cnt_r;
    logic                   err_r;
    logic [DATA_WIDTH-1:0]  rdata_r;

    logic [NUM_LANES-1:0]   onehot;
    logic [NUM_LANES-1:0]   req_mask;
    logic                   lane_ok;
    logic                   illegal;
    logic [NUM_LANES-1:0]   pend_left;
    logic                   timeout_hit;
    logic [16:0]            cnt_inc;
    logic [DATA_WIDTH-1:0]  lane_data;

    always_comb begin
        onehot    = '0;
        lane_data = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            onehot[i] = (32'(mgmt_lane) == i);
            if (32'(lane_r) == i)
                lane_data = drp_do[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign lane_ok = (32'(mgmt_lane) < 32'(NUM_LANES));

`ifdef BERT_DRP_BROADCAST_EN
    assign illegal  = mgmt_broadcast ? ~mgmt_we : ~lane_ok;
    assign req_mask = mgmt_broadcast ? '1 : onehot;
`else
    assign illegal  = mgmt_broadcast | ~lane_ok;
    assign req_mask = onehot;
`endif

    // Timeout is judged on the post-increment count so the abort lands TIMEOUT cycles after ISSUE.
    assign pend_left   = pend_r & ~drp_rdy;
    assign cnt_inc     = {1'b0, cnt_r} + 17'd1;
    assign timeout_hit = (cnt_inc >= 17'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        drp_en     = '0;
        drp_we     = '0;
        mgmt_done  = 1'b0;
        mgmt_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mgmt_en)
                    state_next = illegal ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                drp_en     = mask_r;
                drp_we     = mask_r & {NUM_LANES{we_r}};
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (pend_left == '0 || timeout_hit)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                mgmt_done  = 1'b1;
                mgmt_err   = err_r;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign mgmt_busy  = (state != ST_IDLE);
    assign mgmt_rdata = rdata_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            we_r     <= 1'b0;
            lane_r   <= '0;
            mask_r   <= '0;
            pend_r   <= '0;
            cnt_r    <= '0;
            err_r    <= 1'b0;
            rdata_r  <= '0;
            drp_addr <= '0;
            drp_di   <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (mgmt_en) begin
                        we_r     <= mgmt_we;
                        lane_r   <= mgmt_lane;
                        drp_addr <= mgmt_addr;
                        drp_di   <= mgmt_wdata;
                        mask_r   <= illegal ? '0 : req_mask;
                        err_r    <= illegal;
                        if (illegal)
                            rdata_r <= '0;
                    end
                end
                ST_ISSUE: begin
                    pend_r <= mask_r;
                    cnt_r  <= '0;
                end
                ST_WAIT: begin
                    pend_r <= pend_left;
                    cnt_r  <= cnt_r + 16'd1;
                    // Completion takes priority over a simultaneous timeout.
                    if (pend_left == '0) begin
                        err_r   <= 1'b0;
                        rdata_r <= we_r ? '0 : lane_data;
                    end else if (timeout_hit) begin
                        err_r   <= 1'b1;
                        rdata_r <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bert_drp_arbiter.sv
// Scoreboard bench for bert_drp_arbiter with NUM_LANES=3, TIMEOUT=8.
// Broadcast expectations follow whether BERT_DRP_BROADCAST_EN is defined.
module tb_bert_drp_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mgmt_en;
    logic        mgmt_we;
    logic [1:0]  mgmt_lane;
    logic        mgmt_broadcast;
    logic [8:0]  mgmt_addr;
    logic [15:0] mgmt_wdata;
    logic [15:0] mgmt_rdata;
    logic        mgmt_done;
    logic        mgmt_err;
    logic        mgmt_busy;
    logic [2:0]  drp_en;
    logic [2:0]  drp_we;
    logic [8:0]  drp_addr;
    logic [15:0] drp_di;
    logic [47:0] drp_do;
    logic [2:0]  drp_rdy;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    bert_drp_arbiter #(
        .NUM_LANES (3),
        .ADDR_WIDTH(9),
        .DATA_WIDTH(16),
        .TIMEOUT   (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mgmt_en       (mgmt_en),
        .mgmt_we       (mgmt_we),
        .mgmt_lane     (mgmt_lane),
        .mgmt_broadcast(mgmt_broadcast),
        .mgmt_addr     (mgmt_addr),
        .mgmt_wdata    (mgmt_wdata),
        .mgmt_rdata    (mgmt_rdata),
        .mgmt_done     (mgmt_done),
        .mgmt_err      (mgmt_err),
        .mgmt_busy     (mgmt_busy),
        .drp_en        (drp_en),
        .drp_we        (drp_we),
        .drp_addr      (drp_addr),
        .drp_di        (drp_di),
        .drp_do        (drp_do),
        .drp_rdy       (drp_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every completion pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mgmt_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rdata", mgmt_rdata, mon_e.rdata);
                check("err", mgmt_err, mon_e.err);
            end
        end else if (mgmt_err) begin
            check("err_without_done", mgmt_err, 0);
        end
    end

    task automatic push_exp(input logic [15:0] rdata, input logic err);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    task automatic request(input logic we, input logic [1:0] lane, input logic bcast,
                           input logic [8:0] addr, input logic [15:0] wd);
        @(negedge clk);
        mgmt_en        = 1'b1;
        mgmt_we        = we;
        mgmt_lane      = lane;
        mgmt_broadcast = bcast;
        mgmt_addr      = addr;
        mgmt_wdata     = wd;
    endtask

    // rdy arrives dly cycles after the ISSUE cycle; spur drives other lanes meanwhile;
    // poke fires a stray mgmt_en during WAIT, which must be dropped.
    task automatic unicast(input logic we, input logic [1:0] lane, input logic [8:0] addr,
                           input logic [15:0] wd, input int unsigned dly, input logic [15:0] dout,
                           input logic [2:0] spur, input logic poke);
        logic [2:0] oh;
        oh = 3'b001 << lane;
        push_exp(we ? 16'h0 : dout, 1'b0);
        request(we, lane, 1'b0, addr, wd);
        @(negedge clk);
        mgmt_en = 1'b0;
        check("issue_en", drp_en, oh);
        check("issue_we", drp_we, we ? oh : 3'b000);
        check("issue_addr", drp_addr, addr);
        check("issue_di", drp_di, wd);
        check("issue_busy", mgmt_busy, 1);
        for (int unsigned c = 2; c <= dly + 1; c++) begin
            @(negedge clk);
            if (c == 2) check("wait_en", drp_en, 0);
            check("early_done", mgmt_done, 0);
            if (poke && c == 3) begin
                mgmt_en   = 1'b1;
                mgmt_addr = ~addr;
                mgmt_lane = 2'd0;
            end else begin
                mgmt_en = 1'b0;
            end
            if (c == dly + 1) begin
                drp_rdy = oh;
                drp_do  = {3{16'hDEAD}};
                drp_do[lane*16 +: 16] = dout;
            end else begin
                drp_rdy = spur;
            end
        end
        @(negedge clk);
        drp_rdy = '0;
        mgmt_en = 1'b0;
        check("done_latency", mgmt_done, 1);
        check("hold_addr", drp_addr, addr);
        check("done_busy", mgmt_busy, 1);
    endtask

    task automatic illegal_req(input logic we, input logic [1:0] lane, input logic bcast);
        push_exp(16'h0, 1'b1);
        request(we, lane, bcast, 9'h011, 16'h2222);
        @(negedge clk);
        mgmt_en = 1'b0;
        check("illegal_en", drp_en, 0);
        check("illegal_done", mgmt_done, 1);
        @(negedge clk);
        check("illegal_idle", mgmt_busy, 0);
        check("illegal_en_after", drp_en, 0);
    endtask

    task automatic timeout_case();
        push_exp(16'h0, 1'b1);
        request(1'b0, 2'd0, 1'b0, 9'h0AA, 16'h0);
        @(negedge clk);
        mgmt_en = 1'b0;
        check("to_issue_en", drp_en, 3'b001);
        for (int unsigned c = 2; c <= 8; c++) begin
            @(negedge clk);
            check("to_early_done", mgmt_done, 0);
        end
        @(negedge clk);
        check("to_done", mgmt_done, 1);
        for (int unsigned c = 10; c <= 13; c++) begin
            @(negedge clk);
            drp_rdy = (c == 11) ? 3'b001 : 3'b000;
            check("to_late_done", mgmt_done, 0);
            check("to_late_busy", mgmt_busy, 0);
        end
    endtask

    task automatic broadcast_case();
        logic [2:0] sched [4];
        sched[0] = 3'b000;
        sched[1] = 3'b100;
        sched[2] = 3'b001;
        sched[3] = 3'b010;
`ifdef BERT_DRP_BROADCAST_EN
        push_exp(16'h0, 1'b0);
`else
        push_exp(16'h0, 1'b1);
`endif
        request(1'b1, 2'd0, 1'b1, 9'h123, 16'hABCD);
        @(negedge clk);
        mgmt_en = 1'b0;
`ifdef BERT_DRP_BROADCAST_EN
        check("bc_en", drp_en, 3'b111);
        check("bc_we", drp_we, 3'b111);
        check("bc_di", drp_di, 16'hABCD);
        check("bc_issue_done", mgmt_done, 0);
`else
        check("bc_en", drp_en, 0);
        check("bc_issue_done", mgmt_done, 1);
`endif
        for (int unsigned c = 2; c <= 5; c++) begin
            @(negedge clk);
            drp_rdy = sched[c-2];
            check("bc_wait_en", drp_en, 0);
            check("bc_early_done", mgmt_done, 0);
        end
        @(negedge clk);
        drp_rdy = '0;
`ifdef BERT_DRP_BROADCAST_EN
        check("bc_done", mgmt_done, 1);
`else
        check("bc_no_done", mgmt_done, 0);
`endif
    endtask

    task automatic reset_case();
        request(1'b0, 2'd1, 1'b0, 9'h077, 16'h0);
        @(negedge clk);
        mgmt_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_drp_en", drp_en, 0);
        check("rst_drp_addr", drp_addr, 0);
        check("rst_busy", mgmt_busy, 0);
        check("rst_rdata", mgmt_rdata, 0);
        check("rst_done", mgmt_done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drp_rdy = 3'b010;
        @(negedge clk);
        drp_rdy = 3'b000;
        for (int unsigned c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_late_done", mgmt_done, 0);
            check("rst_late_busy", mgmt_busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        mgmt_en        = 1'b0;
        mgmt_we        = 1'b0;
        mgmt_lane      = '0;
        mgmt_broadcast = 1'b0;
        mgmt_addr      = '0;
        mgmt_wdata     = '0;
        drp_do         = '0;
        drp_rdy        = '0;
        repeat (3) @(negedge clk);
        check("reset_rdata", mgmt_rdata, 0);
        check("reset_done", mgmt_done, 0);
        check("reset_err", mgmt_err, 0);
        check("reset_busy", mgmt_busy, 0);
        check("reset_drp_en", drp_en, 0);
        check("reset_drp_we", drp_we, 0);
        check("reset_drp_addr", drp_addr, 0);
        check("reset_drp_di", drp_di, 0);
        rst = 1'b0;

        unicast(1'b0, 2'd1, 9'h05F, 16'h0000, 3, 16'hBEEF, 3'b000, 1'b0);
        unicast(1'b1, 2'd0, 9'h040, 16'h1234, 5, 16'h7777, 3'b010, 1'b0);
        unicast(1'b0, 2'd2, 9'h1C3, 16'h0000, 1, 16'hA5A5, 3'b000, 1'b0);
        illegal_req(1'b0, 2'd3, 1'b0);
        unicast(1'b0, 2'd0, 9'h0F0, 16'h0000, 7, 16'hC3C3, 3'b000, 1'b0);
        timeout_case();
        broadcast_case();
        illegal_req(1'b0, 2'd0, 1'b1);
        unicast(1'b0, 2'd2, 9'h155, 16'h0000, 4, 16'h5A5A, 3'b011, 1'b1);
        reset_case();
        unicast(1'b0, 2'd1, 9'h033, 16'h0000, 2, 16'h1111, 3'b000, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
